// File: rtl/latch_ex_mem.sv
// latch_ex_mem: EX/MEM pipeline register with load/store alignment check and ALU bypass tap; EXMEM_DEBUG_EN adds o_dbg_count.
// Latency: 1 cycle, and fwd_* is combinational from the registered entry.
// Backpressure: stall holds every register, flush inserts a bubble, and flush wins over stall.
module latch_ex_mem #(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [NBITS-1:0] result_op,
  input  logic             zero,
  input  logic [NBITS-1:0] store_data,
  input  logic [4:0]       reg_dest,
  input  logic [NBITS-1:0] pc_plus8,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             mem_to_reg,
  input  logic             link,
  input  logic [1:0]       mem_width,
  input  logic             mem_unsigned,
  output logic             o_valid,
  output logic [NBITS-1:0] o_result,
  output logic             o_zero,
  output logic [NBITS-1:0] o_store_data,
  output logic [4:0]       o_reg_dest,
  output logic [NBITS-1:0] o_pc_plus8,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_reg_write,
  output logic             o_mem_to_reg,
  output logic             o_link,
  output logic [1:0]       o_mem_width,
  output logic             o_mem_unsigned,
  output logic             o_exc_misaligned,
  output logic [NBITS-1:0] o_bad_addr,
  output logic             fwd_valid,
  output logic [4:0]       fwd_reg,
  output logic [NBITS-1:0] fwd_data
`ifdef EXMEM_DEBUG_EN
  ,
  output logic [31:0]      o_dbg_count
`endif
);

  logic misalign;
  logic exc;

  // Width code 10 is treated as a word access.
  always_comb begin
    misalign = 1'b0;
    case (mem_width)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = result_op[0];
      default: misalign = |result_op[1:0];
    endcase
  end

  assign exc = i_valid & (mem_read | mem_write) & misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid          <= 1'b0;
      o_result         <= '0;
      o_zero           <= 1'b0;
      o_store_data     <= '0;
      o_reg_dest       <= '0;
      o_pc_plus8       <= '0;
      o_mem_read       <= 1'b0;
      o_mem_write      <= 1'b0;
      o_reg_write      <= 1'b0;
      o_mem_to_reg     <= 1'b0;
      o_link           <= 1'b0;
      o_mem_width      <= '0;
      o_mem_unsigned   <= 1'b0;
      o_exc_misaligned <= 1'b0;
      o_bad_addr       <= '0;
    end else if (flush) begin
      o_valid          <= 1'b0;
      o_result         <= '0;
      o_zero           <= 1'b0;
      o_store_data     <= '0;
      o_reg_dest       <= '0;
      o_pc_plus8       <= '0;
      o_mem_read       <= 1'b0;
      o_mem_write      <= 1'b0;
      o_reg_write      <= 1'b0;
      o_mem_to_reg     <= 1'b0;
      o_link           <= 1'b0;
      o_mem_width      <= '0;
      o_mem_unsigned   <= 1'b0;
      o_exc_misaligned <= 1'b0;
      o_bad_addr       <= '0;
    end else if (!stall) begin
      o_valid          <= i_valid;
      o_result         <= result_op;
      o_zero           <= zero;
      o_store_data     <= store_data;
      o_reg_dest       <= reg_dest;
      o_pc_plus8       <= pc_plus8;
      // A faulting access must not touch memory or the register file.
      o_mem_read       <= i_valid & mem_read & ~exc;
      o_mem_write      <= i_valid & mem_write & ~exc;
      o_reg_write      <= i_valid & reg_write & ~exc;
      o_mem_to_reg     <= i_valid & mem_to_reg;
      o_link           <= i_valid & link;
      o_mem_width      <= mem_width;
      o_mem_unsigned   <= mem_unsigned;
      o_exc_misaligned <= exc;
      o_bad_addr       <= exc ? result_op : '0;
    end
  end

  // Loads cannot be bypassed from here: their data only exists after MEM.
  assign fwd_valid = o_valid & o_reg_write & ~o_mem_to_reg & (o_reg_dest != 5'd0);
  assign fwd_reg   = o_reg_dest;
  assign fwd_data  = o_link ? o_pc_plus8 : o_result;

`ifdef EXMEM_DEBUG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_dbg_count <= 32'd0;
    end else if (!flush && !stall && i_valid) begin
      o_dbg_count <= o_dbg_count + 32'd1;
    end
  end
`endif

endmodule
